// File: rtl/axi_lite_led_gpio.sv
// AXI4-Lite slave driving board LEDs with a hardware blink engine and
// synchronised GPI readback. Single-beat transactions only.
module axi_lite_led_gpio #(
    parameter int unsigned GPIO_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter logic [31:0] BLINK_DEFAULT = 32'd25_000_000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [GPIO_WIDTH-1:0] LED_O,
    input  logic [GPIO_WIDTH-1:0] GPI_I
);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] OFF_LED    = ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(32'h04);
    localparam logic [ADDR_WIDTH-1:0] OFF_GPI    = ADDR_WIDTH'(32'h08);
    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(32'h0C);
    localparam logic [ADDR_WIDTH-1:0] OFF_PERIOD = ADDR_WIDTH'(32'h10);

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(32'h3);
    endfunction

    w_state_t               w_state_r, w_next_s;
    r_state_t               r_state_r, r_next_s;
    logic                   aw_ready_r, w_ready_r, bvalid_r, ar_ready_r, rvalid_r;
    logic [1:0]             bresp_r, rresp_r;
    logic [31:0]            rdata_r;
    logic [ADDR_WIDTH-1:0]  aw_addr_r;
    logic [31:0]            w_data_r;
    logic [3:0]             w_strb_r;
    logic                   aw_hs_s, w_hs_s, ar_hs_s, wr_en_s;
    logic [ADDR_WIDTH-1:0]  wr_addr_s;
    logic [31:0]            wr_data_s;
    logic [3:0]             wr_strb_s;
    logic                   wr_led_s, wr_mask_s, wr_ctrl_s, wr_period_s, wr_ok_s;
    logic [31:0]            rd_data_s;
    logic [1:0]             rd_resp_s;
    logic [GPIO_WIDTH-1:0]  led_data_r, blink_mask_r, led_out_r;
    logic [GPIO_WIDTH-1:0]  gpi_sync1_r, gpi_sync2_r;
    logic                   blink_en_r, blink_phase_r, blink_wrap_s, blink_clear_s;
    logic [31:0]            blink_period_r, blink_cnt_r;

    assign aw_hs_s = S_AXI_AWVALID && aw_ready_r;
    assign w_hs_s  = S_AXI_WVALID && w_ready_r;
    assign ar_hs_s = S_AXI_ARVALID && ar_ready_r;

    // A half-latched transaction completes with the latched side plus the live side.
    assign wr_addr_s = (w_state_r == W_HAVE_AW) ? aw_addr_r : S_AXI_AWADDR;
    assign wr_data_s = (w_state_r == W_HAVE_W)  ? w_data_r  : S_AXI_WDATA;
    assign wr_strb_s = (w_state_r == W_HAVE_W)  ? w_strb_r  : S_AXI_WSTRB;

    // Write channel next-state logic and write strobe generation.
    always_comb begin
        w_next_s = w_state_r;
        wr_en_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_next_s = W_RESP;
                    wr_en_s  = 1'b1;
                end else if (aw_hs_s) begin
                    w_next_s = W_HAVE_AW;
                end else if (w_hs_s) begin
                    w_next_s = W_HAVE_W;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_s) begin
                    w_next_s = W_RESP;
                    wr_en_s  = 1'b1;
                end else begin
                    w_next_s = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_s) begin
                    w_next_s = W_RESP;
                    wr_en_s  = 1'b1;
                end else begin
                    w_next_s = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_RESP;
                end
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write address decode; the GPI offset is a silent read-only target.
    always_comb begin
        wr_led_s    = 1'b0;
        wr_mask_s   = 1'b0;
        wr_ctrl_s   = 1'b0;
        wr_period_s = 1'b0;
        wr_ok_s     = 1'b1;
        case (word_addr(wr_addr_s))
            OFF_LED:    wr_led_s    = wr_en_s;
            OFF_MASK:   wr_mask_s   = wr_en_s;
            OFF_GPI:    wr_ok_s     = 1'b1;
            OFF_CTRL:   wr_ctrl_s   = wr_en_s;
            OFF_PERIOD: wr_period_s = wr_en_s;
            default:    wr_ok_s     = 1'b0;
        endcase
    end

    // Write channel state, handshake outputs and half-transaction latches.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_r  <= W_IDLE;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            aw_addr_r  <= '0;
            w_data_r   <= 32'h0;
            w_strb_r   <= 4'h0;
        end else begin
            w_state_r  <= w_next_s;
            aw_ready_r <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_W);
            w_ready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_AW);
            bvalid_r   <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                aw_addr_r <= S_AXI_AWADDR;
            end
            if (w_hs_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
            if (wr_en_s) begin
                bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read mux samples pre-write register values.
    always_comb begin
        rd_data_s = 32'h0;
        rd_resp_s = RESP_OKAY;
        case (word_addr(S_AXI_ARADDR))
            OFF_LED:    rd_data_s = 32'(led_data_r);
            OFF_MASK:   rd_data_s = 32'(blink_mask_r);
            OFF_GPI:    rd_data_s = 32'(gpi_sync2_r);
            OFF_CTRL:   rd_data_s = {30'd0, blink_phase_r, blink_en_r};
            OFF_PERIOD: rd_data_s = blink_period_r;
            default:    rd_resp_s = RESP_SLVERR;
        endcase
    end

    // Read channel next-state logic.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_next_s = R_DATA;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_DATA;
                end
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read channel state and registered response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0;
            rresp_r    <= RESP_OKAY;
        end else begin
            r_state_r  <= r_next_s;
            ar_ready_r <= (r_next_s == R_IDLE);
            rvalid_r   <= (r_next_s == R_DATA);
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    // Periods 0 and 1 both degenerate to a toggle every cycle.
    assign blink_wrap_s  = (blink_period_r <= 32'd1) || (blink_cnt_r == blink_period_r - 32'd1);
    assign blink_clear_s = wr_ctrl_s && wr_strb_s[0] && !wr_data_s[0];

    // Register file, blink engine, GPI synchroniser and LED output stage.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            led_data_r     <= '0;
            blink_mask_r   <= '0;
            blink_en_r     <= 1'b0;
            blink_phase_r  <= 1'b0;
            blink_period_r <= BLINK_DEFAULT;
            blink_cnt_r    <= 32'h0;
            gpi_sync1_r    <= '0;
            gpi_sync2_r    <= '0;
            led_out_r      <= '0;
        end else begin
            gpi_sync1_r <= GPI_I;
            gpi_sync2_r <= gpi_sync1_r;
            if (wr_led_s) begin
                led_data_r <= GPIO_WIDTH'(apply_strb(32'(led_data_r), wr_data_s, wr_strb_s));
            end
            if (wr_mask_s) begin
                blink_mask_r <= GPIO_WIDTH'(apply_strb(32'(blink_mask_r), wr_data_s, wr_strb_s));
            end
            if (wr_period_s) begin
                blink_period_r <= apply_strb(blink_period_r, wr_data_s, wr_strb_s);
            end
            if (wr_ctrl_s && wr_strb_s[0]) begin
                blink_en_r <= wr_data_s[0];
            end
            if (blink_clear_s) begin
                blink_cnt_r   <= 32'h0;
                blink_phase_r <= 1'b0;
            end else if (wr_period_s) begin
                blink_cnt_r <= 32'h0;
            end else if (blink_en_r) begin
                if (blink_wrap_s) begin
                    blink_cnt_r   <= 32'h0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + 32'd1;
                end
            end
            led_out_r <= led_data_r ^ (blink_phase_r ? blink_mask_r : '0);
        end
    end

    assign S_AXI_AWREADY = aw_ready_r;
    assign S_AXI_WREADY  = w_ready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = ar_ready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign LED_O         = led_out_r;

endmodule

// File: tb/tb_axi_lite_led_gpio.sv
// Scoreboard bench for axi_lite_led_gpio: expected B/R responses are queued
// when a transaction is issued and checked by a monitor at the handshake.
module tb_axi_lite_led_gpio;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [4:0]  S_AXI_AWADDR = 5'h0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = 32'h0;
    logic [3:0]  S_AXI_WSTRB = 4'h0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [4:0]  S_AXI_ARADDR = 5'h0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic [3:0]  LED_O;
    logic [3:0]  GPI_I;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    assign GPI_I = LED_O;

    axi_lite_led_gpio dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .LED_O(LED_O), .GPI_I(GPI_I)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every B/R handshake.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
                else check_eq("bresp", 64'(S_AXI_BRESP), 64'(bq.pop_front()));
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (rq.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
                else check_eq("rresp_rdata", 64'({S_AXI_RRESP, S_AXI_RDATA}), 64'(rq.pop_front()));
            end
        end
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input bit wait_b);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit got_b   = 1'b0;
        bq.push_back(exp_resp);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            @(posedge ACLK); #1;
            if (aw_done) S_AXI_AWVALID = 1'b0;
            if (w_done) S_AXI_WVALID = 1'b0;
        end
        if (!(aw_done && w_done)) check_eq("aw_w_timeout", 64'd0, 64'd1);
        if (wait_b) begin
            for (int n = 0; n < 50 && !got_b; n++) begin
                @(negedge ACLK);
                if (S_AXI_BVALID && S_AXI_BREADY) got_b = 1'b1;
            end
            if (!got_b) check_eq("b_timeout", 64'd0, 64'd1);
            @(posedge ACLK); #1;
        end
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data);
        bit ar_done = 1'b0;
        bit got_r   = 1'b0;
        rq.push_back({exp_resp, exp_data});
        @(posedge ACLK); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 50 && !ar_done; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1'b1;
            @(posedge ACLK); #1;
            if (ar_done) S_AXI_ARVALID = 1'b0;
        end
        if (!ar_done) check_eq("ar_timeout", 64'd0, 64'd1);
        for (int n = 0; n < 50 && !got_r; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID && S_AXI_RREADY) got_r = 1'b1;
        end
        if (!got_r) check_eq("r_timeout", 64'd0, 64'd1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        logic [3:0] prev_led;
        int run_len;
        int n_runs;
        int n_bad;
        bit w_done;
        bit aw_done;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("rst_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
        check_eq("rst_valid", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'd0);
        check_eq("rst_led", 64'(LED_O), 64'd0);
        check_eq("rst_rdata", 64'({S_AXI_RRESP, S_AXI_RDATA, S_AXI_BRESP}), 64'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("ready_after_rst", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);
        do_read(5'h10, 2'b00, 32'd25_000_000);

        // Basic write, loopback readback through the synchroniser
        do_write(5'h00, 32'hDEADA5A5, 4'hF, 2'b00, 1'b1);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("led_after_write", 64'(LED_O), 64'h5);
        do_read(5'h08, 2'b00, 32'h5);
        do_read(5'h00, 2'b00, 32'h5);

        // W three cycles before AW, BREADY held low for four cycles
        S_AXI_BREADY = 1'b0;
        bq.push_back(2'b00);
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        w_done = 1'b0;
        for (int n = 0; n < 50 && !w_done; n++) begin
            @(negedge ACLK);
            if (S_AXI_WREADY) w_done = 1'b1;
            @(posedge ACLK); #1;
        end
        S_AXI_WVALID = 1'b0;
        check_eq("w_first_hs", 64'(w_done), 64'd1);
        @(negedge ACLK);
        check_eq("w_latched_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'b10);
        repeat (2) @(posedge ACLK);
        #1;
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        aw_done = 1'b0;
        for (int n = 0; n < 50 && !aw_done; n++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) aw_done = 1'b1;
            @(posedge ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        check_eq("aw_second_hs", 64'(aw_done), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check_eq("bvalid_held", 64'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 64'b100);
            @(posedge ACLK);
        end
        #1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("bvalid_released", 64'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 64'b011);

        // Byte strobes
        do_write(5'h00, 32'h0000000F, 4'h2, 2'b00, 1'b1);
        do_read(5'h00, 2'b00, 32'h5);
        do_write(5'h01, 32'h0000000F, 4'h1, 2'b00, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("led_strb1", 64'(LED_O), 64'hF);
        do_write(5'h00, 32'h00000005, 4'h1, 2'b00, 1'b1);

        // Blink engine
        do_write(5'h04, 32'h3, 4'hF, 2'b00, 1'b1);
        do_write(5'h10, 32'd4, 4'hF, 2'b00, 1'b1);
        do_read(5'h04, 2'b00, 32'h3);
        do_read(5'h10, 2'b00, 32'd4);
        do_write(5'h0C, 32'h1, 4'hF, 2'b00, 1'b1);
        @(negedge ACLK);
        prev_led = LED_O;
        run_len = 1; n_runs = 0; n_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            if (LED_O != 4'h5 && LED_O != 4'h6) n_bad++;
            if (LED_O == prev_led) begin
                run_len++;
            end else begin
                if (n_runs > 0 || i > 0) check_eq("blink_run_len", 64'(run_len), 64'd4);
                n_runs++;
                run_len = 1;
                prev_led = LED_O;
            end
        end
        check_eq("blink_values", 64'(n_bad), 64'd0);
        check_eq("blink_toggles", 64'(n_runs >= 5), 64'd1);
        do_write(5'h0C, 32'h0, 4'hF, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            check_eq("led_blink_off", 64'(LED_O), 64'h5);
        end
        do_read(5'h0C, 2'b00, 32'h0);

        // Unmapped offsets and read-only register
        do_read(5'h14, 2'b10, 32'h0);
        do_write(5'h1C, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b1);
        do_write(5'h08, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b1);
        do_read(5'h00, 2'b00, 32'h5);
        do_read(5'h04, 2'b00, 32'h3);
        do_read(5'h10, 2'b00, 32'd4);
        do_read(5'h08, 2'b00, 32'h5);

        // Reset while a write response is pending
        S_AXI_BREADY = 1'b0;
        do_write(5'h00, 32'hF, 4'h1, 2'b00, 1'b0);
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("pre_rst_bvalid", 64'(S_AXI_BVALID), 64'd1);
        check_eq("pre_rst_led", 64'(LED_O), 64'hF);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check_eq("mid_rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        check_eq("mid_rst_led", 64'(LED_O), 64'h0);
        bq.delete();
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        S_AXI_BREADY = 1'b1;
        do_read(5'h10, 2'b00, 32'd25_000_000);
        do_read(5'h00, 2'b00, 32'h0);

        repeat (2) @(posedge ACLK);
        check_eq("bq_empty", 64'(bq.size()), 64'd0);
        check_eq("rq_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
